stream_slave: RTL and testbench

Receive-side stage directly downstream of the marker-inserting stream master. Accepts the master's valid/ready word stream and strips marker words according to `marker_pos`. Checks that every expected marker slot carries the all-ones marker, stores payload words in an internal show-ahead FIFO for the next consumer, and reports frame boundaries from `last`.

---
 rtl/stream_slave.sv | 147 ++++++++++++++
 tb/tb_stream_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_slave.sv
// stream_slave: receive stage that strips marker words from a framed stream,
// checks them, and buffers payload words in a show-ahead FIFO.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   valid, data_in      upstream word and its valid
//   last                upstream end-of-frame flag (qualified by handshake)
//   marker_pos          framing mode, latched at each group start
//   ready               slave can accept a word
//   read                downstream pop request
//   out_data, out_valid FIFO head word (show-ahead) and not-empty flag
//   frame_done          one-cycle pulse per completed frame
//   frame_cnt           completed frame count, wraps
//   marker_err          one-cycle pulse on marker mismatch
module stream_slave #(
    parameter int PACK_SIZE = 8,
    parameter int MARK_SIZE = 8,
    parameter int BUFF_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [PACK_SIZE-1:0] data_in,
    input  logic                 last,
    input  logic [1:0]           marker_pos,
    output logic                 ready,
    input  logic                 read,
    output logic [PACK_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt,
    output logic                 marker_err
);

    localparam int N  = MARK_SIZE / PACK_SIZE;
    localparam int MW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(BUFF_SIZE);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {PRE, DATA, POST} state_t;

    state_t          state;
    state_t          eff;
    logic            gstart;
    logic [1:0]      mode_q;
    logic [1:0]      mode;
    logic [MW-1:0]   mcnt;

    logic [PACK_SIZE-1:0] mem [BUFF_SIZE];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   cnt;

    logic hs, is_mark, mlast, full, push, pop;

    // At a group start the first word's role comes straight from marker_pos,
    // so the effective state is resolved before the mode register is loaded.
    assign mode = gstart ? marker_pos : mode_q;

    always_comb begin
        eff = state;
        if (gstart)
            eff = mode[1] ? PRE : DATA;
    end

    assign full      = (cnt == CW'(BUFF_SIZE));
    assign out_valid = (cnt != '0);
    assign out_data  = out_valid ? mem[rptr] : '0;
    assign ready     = ~reset & ~((eff == DATA) & full);
    assign hs        = valid & ready;
    assign is_mark   = (data_in == {PACK_SIZE{1'b1}});
    assign mlast     = (mcnt == MW'(N - 1));
    assign push      = hs & (eff == DATA);
    assign pop       = read & out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PRE;
            gstart     <= 1'b1;
            mode_q     <= marker_pos;
            mcnt       <= '0;
            marker_err <= 1'b0;
        end else begin
            marker_err <= 1'b0;
            if (hs) begin
                if (gstart)
                    mode_q <= marker_pos;
                unique case (eff)
                    PRE, POST: begin
                        if (!is_mark) begin
                            marker_err <= 1'b1;
                            mcnt       <= '0;
                            gstart     <= 1'b1;
                        end else if (mlast) begin
                            mcnt   <= '0;
                            state  <= DATA;
                            gstart <= (eff == POST);
                        end else begin
                            mcnt   <= mcnt + MW'(1);
                            state  <= eff;
                            gstart <= 1'b0;
                        end
                    end
                    DATA: begin
                        state  <= POST;
                        gstart <= ~mode[0];
                    end
                    default: gstart <= 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            if (push & ~pop)
                cnt <= cnt + CW'(1);
            else if (pop & ~push)
                cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= hs & last;
            if (hs & last)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_stream_slave.sv
// tb_stream_slave: directed table-driven bench for stream_slave
// plus hand-written full, concurrent push/pop and reset sequences.
module tb_stream_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [7:0] data_in;
    logic       last;
    logic [1:0] marker_pos;
    logic       ready;
    logic       read;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_done;
    logic [15:0] frame_cnt;
    logic       marker_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stream_slave #(
        .PACK_SIZE(8),
        .MARK_SIZE(8),
        .BUFF_SIZE(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .data_in   (data_in),
        .last      (last),
        .marker_pos(marker_pos),
        .ready     (ready),
        .read      (read),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt),
        .marker_err(marker_err)
    );

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         l;
        logic [1:0] mp;
        bit         rd;
        bit         rdy;
        bit         ov;
        logic [7:0] od;
        bit         fd;
        bit         me;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] q[$];

    function automatic vec_t mk(bit v, logic [7:0] d, bit l,
                                logic [1:0] mp, bit rd, bit rdy, bit ov,
                                logic [7:0] od, bit fd, bit me,
                                logic [15:0] fc);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.mp = mp; t.rd = rd;
        t.rdy = rdy; t.ov = ov; t.od = od; t.fd = fd; t.me = me; t.fc = fc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input bit v, input logic [7:0] d, input bit l,
                       input logic [1:0] mp, input bit rd);
        @(negedge clk);
        valid = v; data_in = d; last = l; marker_pos = mp; read = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; valid = 0; data_in = 0; last = 0;
        marker_pos = 0; read = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_od", out_data, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_fc", frame_cnt, 0);
        chk("rst_me", marker_err, 0);
        @(negedge clk);
        reset = 1'b0;

        // v d l mp rd | rdy ov od fd me fc
        tbl.push_back(mk(1,8'h11,0,0,0, 1,1,8'h11,0,0,0));
        tbl.push_back(mk(1,8'h22,0,0,0, 1,1,8'h11,0,0,0));
        tbl.push_back(mk(1,8'h33,1,0,0, 1,1,8'h11,1,0,1));
        tbl.push_back(mk(0,8'h00,0,0,0, 1,1,8'h11,0,0,1));
        tbl.push_back(mk(0,8'h00,0,0,1, 1,1,8'h22,0,0,1));
        tbl.push_back(mk(0,8'h00,0,0,1, 1,1,8'h33,0,0,1));
        tbl.push_back(mk(0,8'h00,0,0,1, 1,0,8'h00,0,0,1));
        tbl.push_back(mk(1,8'hFF,0,3,0, 1,0,8'h00,0,0,1));
        tbl.push_back(mk(1,8'h5A,0,3,0, 1,1,8'h5A,0,0,1));
        tbl.push_back(mk(1,8'hFF,0,3,0, 1,1,8'h5A,0,0,1));
        tbl.push_back(mk(1,8'hFF,0,3,0, 1,1,8'h5A,0,0,1));
        tbl.push_back(mk(1,8'hA5,0,3,0, 1,1,8'h5A,0,0,1));
        tbl.push_back(mk(1,8'hFF,0,3,0, 1,1,8'h5A,0,0,1));
        tbl.push_back(mk(0,8'h00,0,3,1, 1,1,8'hA5,0,0,1));
        tbl.push_back(mk(0,8'h00,0,3,1, 1,0,8'h00,0,0,1));
        tbl.push_back(mk(1,8'h7F,0,2,0, 1,0,8'h00,0,1,1));
        tbl.push_back(mk(1,8'hFF,0,2,0, 1,0,8'h00,0,0,1));
        tbl.push_back(mk(1,8'h42,0,2,0, 1,1,8'h42,0,0,1));
        tbl.push_back(mk(0,8'h00,0,2,1, 1,0,8'h00,0,0,1));
        tbl.push_back(mk(1,8'h77,0,1,0, 1,1,8'h77,0,0,1));
        tbl.push_back(mk(1,8'hFF,0,0,0, 1,1,8'h77,0,0,1));
        tbl.push_back(mk(0,8'h00,0,0,1, 1,0,8'h00,0,0,1));
        tbl.push_back(mk(1,8'h10,0,1,0, 1,1,8'h10,0,0,1));
        tbl.push_back(mk(1,8'h20,0,1,0, 1,1,8'h10,0,1,1));
        tbl.push_back(mk(1,8'h30,0,0,0, 1,1,8'h10,0,0,1));
        tbl.push_back(mk(0,8'h00,0,0,1, 1,1,8'h30,0,0,1));
        tbl.push_back(mk(0,8'h00,0,0,1, 1,0,8'h00,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mp, tbl[i].rd);
            chk($sformatf("v%0d_ready", i), ready, tbl[i].rdy);
            tick();
            chk($sformatf("v%0d_ov", i), out_valid, tbl[i].ov);
            chk($sformatf("v%0d_od", i), out_data, tbl[i].od);
            chk($sformatf("v%0d_fd", i), frame_done, tbl[i].fd);
            chk($sformatf("v%0d_me", i), marker_err, tbl[i].me);
            chk($sformatf("v%0d_fc", i), frame_cnt, tbl[i].fc);
        end

        // fill the FIFO, check backpressure and order
        for (int i = 0; i < 8; i++) begin
            drv(1, 8'h80 + 8'(i), 0, 0, 0);
            chk("full_rdy", ready, 1);
            tick();
            chk("full_od", out_data, 8'h80);
        end
        chk("full_rdy_fall", ready, 0);
        drv(1, 8'h88, 0, 0, 0);
        chk("full_9th_rdy", ready, 0);
        tick();
        drv(0, 8'h00, 0, 0, 1);
        chk("full_pop_rdy_pre", ready, 0);
        tick();
        chk("full_pop_rdy_post", ready, 1);
        chk("full_pop_od", out_data, 8'h81);
        for (int i = 1; i < 8; i++) begin
            drv(0, 8'h00, 0, 0, 1);
            tick();
            chk("drain_ov", out_valid, (i < 7) ? 1 : 0);
            chk("drain_od", out_data, (i < 7) ? 8'h81 + 8'(i) : 8'h00);
        end

        // concurrent push and pop at occupancy 4
        for (int i = 0; i < 4; i++) begin
            drv(1, 8'h40 + 8'(i), 0, 0, 0);
            q.push_back(8'h40 + 8'(i));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drv(1, 8'h44 + 8'(i), 0, 0, 1);
            chk("sim_rdy", ready, 1);
            chk("sim_head", out_data, q[0]);
            q.push_back(8'h44 + 8'(i));
            void'(q.pop_front());
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drv(0, 8'h00, 0, 0, 1);
            chk("sim_drain_ov", out_valid, 1);
            chk("sim_drain_od", out_data, q[0]);
            void'(q.pop_front());
            tick();
        end
        chk("sim_empty", out_valid, 0);

        // reset while in POST with 3 words buffered
        drv(1, 8'h01, 0, 1, 0); tick();
        drv(1, 8'hFF, 1, 1, 0); tick();
        drv(1, 8'h02, 0, 1, 0); tick();
        drv(1, 8'hFF, 0, 1, 0); tick();
        drv(1, 8'h03, 0, 1, 0); tick();
        chk("pre_rst_fc", frame_cnt, 2);
        chk("pre_rst_od", out_data, 8'h01);
        drv(0, 8'h00, 0, 1, 0);
        reset = 1'b1;
        #1;
        chk("in_rst_rdy", ready, 0);
        tick();
        chk("post_rst_ov", out_valid, 0);
        chk("post_rst_rdy", ready, 0);
        chk("post_rst_fc", frame_cnt, 0);
        chk("post_rst_od", out_data, 0);
        @(negedge clk);
        reset = 1'b0;
        drv(1, 8'h99, 0, 1, 0);
        chk("rec_rdy", ready, 1);
        tick();
        chk("rec_ov", out_valid, 1);
        chk("rec_od", out_data, 8'h99);
        drv(1, 8'hFF, 0, 1, 0);
        tick();
        chk("rec_me", marker_err, 0);
        chk("rec_od2", out_data, 8'h99);
        drv(0, 8'h00, 0, 1, 1);
        tick();
        chk("rec_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
